dense_mac_unit: RTL

Fully-connected layer compute engine that sits directly downstream of the AXI-Stream interface block in the MNIST CNN accelerator. On `waitSt` it reads the buffered input vector through the interface's address/data port and fetches weights and biases from external ROM ports. It computes OUTDATANUM fixed-point dot products with bias, optional ReLU and saturation, and holds the results in an internal output register file. It then raises `waitFin` so the interface can stream the results out by `out_adr`.

---
 rtl/dense_mac_unit_if.sv | 33 +++
 rtl/dense_mac_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/dense_mac_unit_if.sv
// Start/finish handshake, ROM address/data pairs and result read port
// between the AXI-Stream interface block and dense_mac_unit.
interface dense_mac_unit_if #(
  parameter int DATAWIDTH  = 32,
  parameter int INPDATANUM = 8,
  parameter int OUTDATANUM = 4
);
  localparam int INPADRWIDTH = (INPDATANUM > 1) ? $clog2(INPDATANUM) : 1;
  localparam int OUTADRWIDTH = (OUTDATANUM > 1) ? $clog2(OUTDATANUM) : 1;
  localparam int WADRWIDTH   = (INPDATANUM * OUTDATANUM > 1) ? $clog2(INPDATANUM * OUTDATANUM) : 1;

  logic                   waitSt;
  logic                   waitFin;
  logic [INPADRWIDTH-1:0] inp_adr;
  logic [DATAWIDTH-1:0]   inp_data;
  logic [WADRWIDTH-1:0]   w_adr;
  logic [DATAWIDTH-1:0]   w_data;
  logic [OUTADRWIDTH-1:0] b_adr;
  logic [DATAWIDTH-1:0]   b_data;
  logic [OUTADRWIDTH-1:0] out_adr;
  logic [DATAWIDTH-1:0]   out_data;

  // master is the compute engine; slave is the interface block / ROMs side
  modport master (
    input  waitSt, inp_data, w_data, b_data, out_adr,
    output waitFin, inp_adr, w_adr, b_adr, out_data
  );

  modport slave (
    output waitSt, inp_data, w_data, b_data, out_adr,
    input  waitFin, inp_adr, w_adr, b_adr, out_data
  );
endinterface

// File: rtl/dense_mac_unit.sv
// Fully-connected layer engine: OUTDATANUM dot products of the buffered input
// vector with ROM weights, plus bias, optional ReLU and saturation.
module dense_mac_unit #(
  parameter int DATAWIDTH  = 32,
  parameter int INPDATANUM = 8,
  parameter int OUTDATANUM = 4,
  parameter int FRACBITS   = 8,
  parameter int RELU       = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  dense_mac_unit_if.master bus
);
  localparam int INPADRWIDTH = (INPDATANUM > 1) ? $clog2(INPDATANUM) : 1;
  localparam int OUTADRWIDTH = (OUTDATANUM > 1) ? $clog2(OUTDATANUM) : 1;
  localparam int WADRWIDTH   = (INPDATANUM * OUTDATANUM > 1) ? $clog2(INPDATANUM * OUTDATANUM) : 1;
  localparam int PRODWIDTH   = 2 * DATAWIDTH;
  localparam int ACCWIDTH    = 2 * DATAWIDTH + INPADRWIDTH;
  localparam int SUMWIDTH    = ACCWIDTH + 1;

  localparam logic signed [SUMWIDTH-1:0] SAT_MAX =
    {{(SUMWIDTH - DATAWIDTH + 1){1'b0}}, {(DATAWIDTH - 1){1'b1}}};
  localparam logic signed [SUMWIDTH-1:0] SAT_MIN =
    {{(SUMWIDTH - DATAWIDTH + 1){1'b1}}, {(DATAWIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_STORE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic [INPADRWIDTH-1:0]      r_i;
  logic [OUTADRWIDTH-1:0]      r_j;
  logic signed [ACCWIDTH-1:0]  r_acc;

  logic                        w_last_inp;
  logic                        w_last_out;
  logic [WADRWIDTH-1:0]        w_w_adr;
  logic signed [PRODWIDTH-1:0] w_prod;
  logic signed [ACCWIDTH-1:0]  w_prod_ext;
  logic signed [ACCWIDTH-1:0]  w_shifted;
  logic signed [SUMWIDTH-1:0]  w_sum;
  logic signed [SUMWIDTH-1:0]  w_relu;
  logic [DATAWIDTH-1:0]        w_store_data;
  logic [OUTDATANUM-1:0][DATAWIDTH-1:0] w_out_words;

  assign w_last_inp = (r_i == INPADRWIDTH'(INPDATANUM - 1));
  assign w_last_out = (r_j == OUTADRWIDTH'(OUTDATANUM - 1));
  assign w_w_adr    = WADRWIDTH'(r_j) * WADRWIDTH'(INPDATANUM) + WADRWIDTH'(r_i);

  // Full-width signed product, widened so INPDATANUM terms cannot overflow
  assign w_prod     = $signed(bus.inp_data) * $signed(bus.w_data);
  assign w_prod_ext = {{(ACCWIDTH - PRODWIDTH){w_prod[PRODWIDTH-1]}}, w_prod};

  // Arithmetic shift floors toward -inf before the Q-format bias is added
  assign w_shifted = r_acc >>> FRACBITS;
  assign w_sum     = {w_shifted[ACCWIDTH-1], w_shifted}
                   + {{(SUMWIDTH - DATAWIDTH){bus.b_data[DATAWIDTH-1]}}, bus.b_data};
  assign w_relu    = ((RELU != 0) && w_sum[SUMWIDTH-1]) ? '0 : w_sum;

  always_comb begin
    w_store_data = w_relu[DATAWIDTH-1:0];
    if (w_relu > SAT_MAX) begin
      w_store_data = {1'b0, {(DATAWIDTH - 1){1'b1}}};
    end else if (w_relu < SAT_MIN) begin
      w_store_data = {1'b1, {(DATAWIDTH - 1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.waitSt) w_state_next = S_MAC;
      S_MAC:   if (w_last_inp) w_state_next = S_STORE;
      S_STORE: w_state_next = w_last_out ? S_DONE : S_MAC;
      S_DONE:  if (!bus.waitSt) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Addresses are only meaningful while computing; they idle at zero
  always_comb begin
    bus.waitFin = 1'b0;
    bus.inp_adr = '0;
    bus.w_adr   = '0;
    bus.b_adr   = '0;
    unique case (r_state)
      S_MAC, S_STORE: begin
        bus.inp_adr = r_i;
        bus.w_adr   = w_w_adr;
        bus.b_adr   = r_j;
      end
      S_DONE:  bus.waitFin = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i   <= '0;
      r_j   <= '0;
      r_acc <= '0;
    end else begin
      unique case (r_state)
        S_MAC: begin
          r_acc <= r_acc + w_prod_ext;
          if (!w_last_inp) r_i <= r_i + 1'b1;
        end
        S_STORE: begin
          r_i   <= '0;
          r_acc <= '0;
          r_j   <= w_last_out ? '0 : r_j + 1'b1;
        end
        default: begin
          r_i   <= '0;
          r_j   <= '0;
          r_acc <= '0;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < OUTDATANUM; gi++) begin : g_out_mem
      logic [DATAWIDTH-1:0] r_word;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_word <= '0;
        end else if (r_state == S_STORE && r_j == OUTADRWIDTH'(gi)) begin
          r_word <= w_store_data;
        end
      end
      assign w_out_words[gi] = r_word;
    end
  endgenerate

  assign bus.out_data = w_out_words[bus.out_adr];
endmodule
